// File: rtl/control_fsm.sv
// Multi-cycle RV32 control FSM: sequences fetch, decode, execute, memory and
// write-back, and decodes datapath strobes from the registered state.
// Optional CSR support is enabled by defining CONTROL_FSM_CSR_EN; without it
// SYSTEM instructions trap and write_csr stays 0.
module control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_complete,
    input  logic [6:0] opcode,
    input  logic [2:0] f3,
    input  logic       branch_taken,
    output logic       write_pc_ne,
    output logic       write_pc_ex,
    output logic       write_pc,
    output logic       write_ir,
    output logic       write_rd,
    output logic       write_csr,
    output logic       mem_read,
    output logic       mem_write,
    output logic       addr_sel,
    output logic [1:0] rd_sel,
    output logic [1:0] alu_insel1,
    output logic [1:0] alu_insel2,
    output logic       trap,
    output logic       retire
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic       ADDR_ALU = 1'b0;
    localparam logic       ADDR_PC  = 1'b1;
    localparam logic [1:0] RD_MEM   = 2'b01;
    localparam logic [1:0] RD_CSR   = 2'b10;
    localparam logic [1:0] IN1_PC   = 2'b01;
    localparam logic [1:0] IN1_ZR   = 2'b10;
    localparam logic [1:0] IN2_IM   = 2'b01;
    localparam logic [1:0] IN2_IS   = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t     state;
    logic [6:0] ir_op;
    logic [2:0] ir_f3;

    // State register and instruction-class capture (captured in DECODE)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            ir_op <= 7'd0;
            ir_f3 <= 3'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_complete) state <= S_DECODE;
                end
                S_DECODE: begin
                    ir_op <= opcode;
                    ir_f3 <= f3;
                    case (opcode)
                        OPC_LOAD, OPC_STORE: state <= S_MEM;
                        OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL,
                        OPC_JALR, OPC_BRANCH, OPC_MISC: state <= S_EXEC;
`ifdef CONTROL_FSM_CSR_EN
                        OPC_SYSTEM: state <= S_EXEC;
`endif
                        default: state <= S_TRAP;
                    endcase
                end
                S_EXEC: begin
                    case (ir_op)
                        OPC_JAL, OPC_JALR: state <= S_WB;
                        OPC_BRANCH: state <= branch_taken ? S_WB : S_FETCH;
                        OPC_SYSTEM: state <= (ir_f3 == 3'd0) ? S_TRAP : S_FETCH;
                        default:    state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_complete) state <= S_FETCH;
                end
                S_WB:    state <= S_FETCH;
                S_TRAP:  state <= S_TRAP;
                default: state <= S_TRAP;
            endcase
        end
    end

    // Strobe decode from registered state; everything forced low during reset
    always_comb begin
        write_pc_ne = 1'b0;
        write_pc_ex = 1'b0;
        write_ir    = 1'b0;
        write_rd    = 1'b0;
        write_csr   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        addr_sel    = ADDR_ALU;
        rd_sel      = 2'b00;
        alu_insel1  = 2'b00;
        alu_insel2  = 2'b00;
        trap        = 1'b0;
        retire      = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    addr_sel = ADDR_PC;
                    mem_read = 1'b1;
                    write_ir = mem_complete;
                end
                S_EXEC: begin
                    case (ir_op)
                        OPC_OP: begin
                            write_rd    = 1'b1;
                            write_pc_ne = 1'b1;
                            retire      = 1'b1;
                        end
                        OPC_OPIMM: begin
                            alu_insel2  = IN2_IM;
                            write_rd    = 1'b1;
                            write_pc_ne = 1'b1;
                            retire      = 1'b1;
                        end
                        OPC_LUI: begin
                            alu_insel1  = IN1_ZR;
                            alu_insel2  = IN2_IM;
                            write_rd    = 1'b1;
                            write_pc_ne = 1'b1;
                            retire      = 1'b1;
                        end
                        OPC_AUIPC: begin
                            alu_insel1  = IN1_PC;
                            alu_insel2  = IN2_IM;
                            write_rd    = 1'b1;
                            write_pc_ne = 1'b1;
                            retire      = 1'b1;
                        end
                        OPC_JAL: begin
                            alu_insel1  = IN1_PC;
                            alu_insel2  = IN2_IM;
                            write_pc_ex = 1'b1;
                        end
                        OPC_JALR: begin
                            alu_insel2  = IN2_IM;
                            write_pc_ex = 1'b1;
                        end
                        OPC_BRANCH: begin
                            write_pc_ne = !branch_taken;
                            retire      = !branch_taken;
                        end
                        OPC_MISC: begin
                            write_pc_ne = 1'b1;
                            retire      = 1'b1;
                        end
`ifdef CONTROL_FSM_CSR_EN
                        OPC_SYSTEM: begin
                            if (ir_f3 != 3'd0) begin
                                write_csr   = 1'b1;
                                write_rd    = 1'b1;
                                rd_sel      = RD_CSR;
                                if (ir_f3[2]) begin
                                    alu_insel1 = IN1_ZR;
                                    alu_insel2 = IN2_IM;
                                end
                                write_pc_ne = 1'b1;
                                retire      = 1'b1;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
                S_MEM: begin
                    addr_sel   = ADDR_ALU;
                    alu_insel2 = IN2_IM;
                    mem_read   = (ir_op == OPC_LOAD);
                    mem_write  = (ir_op != OPC_LOAD);
                    if (mem_complete) begin
                        write_pc_ne = 1'b1;
                        retire      = 1'b1;
                        if (ir_op == OPC_LOAD) begin
                            write_rd = 1'b1;
                            rd_sel   = RD_MEM;
                        end
                    end
                end
                S_WB: begin
                    alu_insel1 = IN1_PC;
                    retire     = 1'b1;
                    if (ir_op == OPC_BRANCH) begin
                        alu_insel2  = IN2_IM;
                        write_pc_ex = 1'b1;
                    end else begin
                        alu_insel2 = IN2_IS;
                        write_rd   = 1'b1;
                    end
                end
                S_TRAP:  trap = 1'b1;
                default: ;
            endcase
        end
        write_pc = write_pc_ne | write_pc_ex;
    end

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: table of instructions plus hand-written trap and
// reset sequences; per-cycle expected strobe words go through a queue.
// Honours CONTROL_FSM_CSR_EN to pick the matching SYSTEM expectations.
module tb_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_complete;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic       branch_taken;
    logic       write_pc_ne, write_pc_ex, write_pc, write_ir, write_rd, write_csr;
    logic       mem_read, mem_write, addr_sel, trap, retire;
    logic [1:0] rd_sel, alu_insel1, alu_insel2;

    control_fsm dut (
        .clk(clk), .rst(rst), .mem_complete(mem_complete), .opcode(opcode),
        .f3(f3), .branch_taken(branch_taken),
        .write_pc_ne(write_pc_ne), .write_pc_ex(write_pc_ex), .write_pc(write_pc),
        .write_ir(write_ir), .write_rd(write_rd), .write_csr(write_csr),
        .mem_read(mem_read), .mem_write(mem_write), .addr_sel(addr_sel),
        .rd_sel(rd_sel), .alu_insel1(alu_insel1), .alu_insel2(alu_insel2),
        .trap(trap), .retire(retire)
    );

    always #5 clk = ~clk;

    // Strobe word: pc_ne pc_ex pc ir rd csr mr mw as rd_sel in1 in2 trap retire
    logic [16:0] act;
    assign act = {write_pc_ne, write_pc_ex, write_pc, write_ir, write_rd, write_csr,
                  mem_read, mem_write, addr_sel, rd_sel, alu_insel1, alu_insel2,
                  trap, retire};

    localparam logic [16:0] E_PNE  = 17'h14000;
    localparam logic [16:0] E_PEX  = 17'h0C000;
    localparam logic [16:0] E_IR   = 17'h02000;
    localparam logic [16:0] E_RD   = 17'h01000;
    localparam logic [16:0] E_CSR  = 17'h00800;
    localparam logic [16:0] E_MR   = 17'h00400;
    localparam logic [16:0] E_MW   = 17'h00200;
    localparam logic [16:0] E_AS   = 17'h00100;
    localparam logic [16:0] R_MEM  = 17'h00040;
    localparam logic [16:0] R_CSR  = 17'h00080;
    localparam logic [16:0] A1_PC  = 17'h00010;
    localparam logic [16:0] A1_ZR  = 17'h00020;
    localparam logic [16:0] A2_IM  = 17'h00004;
    localparam logic [16:0] A2_IS  = 17'h00008;
    localparam logic [16:0] E_TRAP = 17'h00002;
    localparam logic [16:0] E_RET  = 17'h00001;

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f;
        logic        bt;
        int          fwait;
        int          mwait;
        logic        is_mem;
        logic [16:0] e1;
        logic        has_wb;
        logic [16:0] e2;
    } vec_t;

    typedef struct {
        logic [16:0] exp;
        string       name;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    function automatic vec_t mkv(string n, logic [6:0] op, logic [2:0] f, logic bt,
                                 int fw, int mw, logic is_mem, logic [16:0] e1,
                                 logic has_wb, logic [16:0] e2);
        vec_t v;
        v.name = n; v.op = op; v.f = f; v.bt = bt; v.fwait = fw; v.mwait = mw;
        v.is_mem = is_mem; v.e1 = e1; v.has_wb = has_wb; v.e2 = e2;
        return v;
    endfunction

    task automatic pop_check();
        sb_t s;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL scoreboard_underflow: got %h required entry", act);
        end else begin
            s = sb_q.pop_front();
            n_checks++;
            if (act !== s.exp) begin
                n_fails++;
                $display("FAIL %s: got %h required %h", s.name, act, s.exp);
            end
        end
    endtask

    task automatic expect_now(string name, logic [16:0] exp);
        sb_t s;
        s.exp = exp; s.name = name;
        sb_q.push_back(s);
        pop_check();
    endtask

    // One clock of stimulus: drive, queue expectation, compare at negedge
    task automatic step(logic mc, logic [16:0] exp, string name);
        sb_t s;
        mem_complete = mc;
        s.exp = exp; s.name = name;
        sb_q.push_back(s);
        @(negedge clk);
        pop_check();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_complete = 1'b0;
        #1;
        expect_now("reset_outputs_now", 17'h0);
        @(negedge clk);
        expect_now("reset_outputs_held", 17'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic fetch_decode(logic [6:0] op, logic [2:0] f, logic bt, int fw, string n);
        opcode = op; f3 = f; branch_taken = bt;
        for (int i = 0; i < fw; i++) step(1'b0, E_MR | E_AS, {n, "_fetch_wait"});
        step(1'b1, E_MR | E_AS | E_IR, {n, "_fetch_done"});
        step(1'b1, 17'h0, {n, "_decode"});
    endtask

    task automatic run_vec(vec_t v);
        fetch_decode(v.op, v.f, v.bt, v.fwait, v.name);
        if (v.is_mem) begin
            for (int i = 0; i < v.mwait; i++) step(1'b0, v.e1, {v.name, "_mem_wait"});
            step(1'b1, v.e2, {v.name, "_mem_done"});
        end else begin
            step(1'b1, v.e1, {v.name, "_exec"});
            if (v.has_wb) step(1'b1, v.e2, {v.name, "_wb"});
        end
    endtask

    task automatic run_trap(string n, logic [6:0] op, logic [2:0] f, logic exec_first);
        fetch_decode(op, f, 1'b0, 0, n);
        if (exec_first) step(1'b1, 17'h0, {n, "_exec"});
        for (int i = 0; i < 100; i++) step(1'($urandom_range(0, 1)), E_TRAP, {n, "_trap_hold"});
        do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_complete = 1'b1; opcode = 7'd0; f3 = 3'd0; branch_taken = 1'b0;

        vecs.push_back(mkv("addi", 7'b0010011, 3'b000, 1'b1, 2, 0, 1'b0,
                           E_RD | E_PNE | A2_IM | E_RET, 1'b0, 17'h0));
        vecs.push_back(mkv("add", 7'b0110011, 3'b000, 1'b0, 0, 0, 1'b0,
                           E_RD | E_PNE | E_RET, 1'b0, 17'h0));
        vecs.push_back(mkv("lui", 7'b0110111, 3'b000, 1'b0, 1, 0, 1'b0,
                           E_RD | E_PNE | A1_ZR | A2_IM | E_RET, 1'b0, 17'h0));
        vecs.push_back(mkv("auipc", 7'b0010111, 3'b000, 1'b0, 0, 0, 1'b0,
                           E_RD | E_PNE | A1_PC | A2_IM | E_RET, 1'b0, 17'h0));
        vecs.push_back(mkv("beq_taken", 7'b1100011, 3'b000, 1'b1, 0, 0, 1'b0,
                           17'h0, 1'b1, A1_PC | A2_IM | E_PEX | E_RET));
        vecs.push_back(mkv("beq_not", 7'b1100011, 3'b000, 1'b0, 1, 0, 1'b0,
                           E_PNE | E_RET, 1'b0, 17'h0));
        vecs.push_back(mkv("jal", 7'b1101111, 3'b000, 1'b0, 0, 0, 1'b0,
                           A1_PC | A2_IM | E_PEX, 1'b1, A1_PC | A2_IS | E_RD | E_RET));
        vecs.push_back(mkv("jalr", 7'b1100111, 3'b000, 1'b0, 0, 0, 1'b0,
                           A2_IM | E_PEX, 1'b1, A1_PC | A2_IS | E_RD | E_RET));
        vecs.push_back(mkv("fence", 7'b0001111, 3'b000, 1'b0, 0, 0, 1'b0,
                           E_PNE | E_RET, 1'b0, 17'h0));
        vecs.push_back(mkv("lw", 7'b0000011, 3'b010, 1'b0, 1, 3, 1'b1,
                           E_MR | A2_IM, 1'b0, E_MR | A2_IM | E_PNE | E_RD | R_MEM | E_RET));
        vecs.push_back(mkv("sw", 7'b0100011, 3'b010, 1'b0, 0, 0, 1'b1,
                           E_MW | A2_IM, 1'b0, E_MW | A2_IM | E_PNE | E_RET));
        vecs.push_back(mkv("sw_wait", 7'b0100011, 3'b010, 1'b1, 0, 2, 1'b1,
                           E_MW | A2_IM, 1'b0, E_MW | A2_IM | E_PNE | E_RET));
`ifdef CONTROL_FSM_CSR_EN
        vecs.push_back(mkv("csrrw", 7'b1110011, 3'b001, 1'b0, 0, 0, 1'b0,
                           E_CSR | E_RD | R_CSR | E_PNE | E_RET, 1'b0, 17'h0));
        vecs.push_back(mkv("csrrwi", 7'b1110011, 3'b101, 1'b0, 0, 0, 1'b0,
                           E_CSR | E_RD | R_CSR | A1_ZR | A2_IM | E_PNE | E_RET, 1'b0, 17'h0));
`endif

        // Reset state, then release between edges
        @(negedge clk);
        expect_now("reset_state", 17'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Store abandoned by reset mid-access; next cycle fetches again
        fetch_decode(7'b0100011, 3'b010, 1'b0, 0, "sw_rst");
        step(1'b0, E_MW | A2_IM, "sw_rst_mem_wait");
        mem_complete = 1'b0;
        #2;
        do_reset();
        step(1'b0, E_MR | E_AS, "post_reset_fetch");
        step(1'b1, E_MR | E_AS | E_IR, "post_reset_fetch_done");
        step(1'b0, 17'h0, "post_reset_decode");
        step(1'b1, E_MW | A2_IM | E_PNE | E_RET, "post_reset_sw_done");

        // Illegal opcode and SYSTEM traps are absorbing until reset
        run_trap("illegal", 7'b0000000, 3'b000, 1'b0);
`ifdef CONTROL_FSM_CSR_EN
        run_trap("ecall", 7'b1110011, 3'b000, 1'b1);
`else
        run_trap("ecall", 7'b1110011, 3'b000, 1'b0);
        run_trap("csrrw_off", 7'b1110011, 3'b001, 1'b0);
`endif

        // Machine recovers after trap reset
        run_vec(vecs[0]);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL scoreboard_drain: got %0d left required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  async active-high reset.
REQ-002 Inputs SHALL be: mem_complete  in  1  memory access done; opcode  in  7  IR opcode; f3  in  3  IR funct3; branch_taken  in  1  comparator result for f3 on rs1/rs2.
REQ-003 Outputs SHALL be, all 1 bit and registered-state decoded: write_pc_ne (PC<=PC+4), write_pc_ex (PC<=ALU), write_pc (OR of both), write_ir, write_rd, write_csr, mem_read, mem_write, addr_sel.
REQ-004 Further outputs SHALL be: rd_sel  out  2; alu_insel1  out  2; alu_insel2  out  2; trap  out  1  halted on illegal/ECALL/EBREAK; retire  out  1  instruction-complete pulse.
REQ-005 Encodings SHALL be: addr_sel ALU=0, PC=1; rd_sel ALU=00, MEM=01, CSR=10; alu_insel1 RS=00, PC=01 (PC of current instruction), ZR=10; alu_insel2 RS=00, IM=01, IS=10 (constant 4).

Function
REQ-006 States SHALL be FETCH, DECODE, EXEC, MEM, WB, TRAP; unlisted outputs are 0 in every state.
REQ-007 FETCH: addr_sel=PC, mem_read=1 held until mem_complete; on mem_complete write_ir=1 and go to DECODE.
REQ-008 DECODE (1 cycle, all outputs 0): LOAD 0000011/STORE 0100011 -> MEM; OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH, MISC-MEM, SYSTEM -> EXEC; any other opcode -> TRAP.
REQ-009 EXEC OP: RS,RS, write_rd, rd_sel=ALU, write_pc_ne; OP-IMM: RS,IM; LUI: ZR,IM; AUIPC: PC,IM; each -> FETCH with retire=1.
REQ-010 EXEC JAL: PC,IM, write_pc_ex -> WB; JALR: RS,IM, write_pc_ex -> WB; WB: PC,IS, write_rd, rd_sel=ALU, retire=1 -> FETCH.
REQ-011 EXEC BRANCH: RS,RS; branch_taken=0 -> write_pc_ne, retire=1, -> FETCH; branch_taken=1 -> WB; branch WB: PC,IM, write_pc_ex, retire=1 -> FETCH.
REQ-012 MEM: addr_sel=ALU, RS,IM, mem_read (LOAD) or mem_write (STORE) held until mem_complete; on it: write_pc_ne, retire=1, LOAD also write_rd with rd_sel=MEM; -> FETCH.
REQ-013 EXEC MISC-MEM: write_pc_ne, retire=1 -> FETCH (FENCE is a no-op).
REQ-014 EXEC SYSTEM with f3!=000: write_csr, write_rd, rd_sel=CSR, alu_insel1=RS (f3[2]=0) or ZR with alu_insel2=IM (f3[2]=1), write_pc_ne, retire=1 -> FETCH; f3=000 -> TRAP with no writes.
REQ-015 TRAP SHALL be absorbing: trap=1, all other outputs 0, exit only by rst.
REQ-016 mem_complete SHALL be ignored outside FETCH and MEM; a mem_complete in the same cycle a request is first raised SHALL complete that access (zero-wait memory).
REQ-017 mem_read/mem_write and addr_sel SHALL stay stable every cycle until mem_complete; never both high.
REQ-018 retire SHALL pulse exactly once per completed instruction, in the cycle the FSM returns to FETCH; write_pc_ne and write_pc_ex SHALL never both be high.

Reset
REQ-019 rst SHALL asynchronously force state FETCH; while rst=1 all outputs SHALL be 0, including trap and retire.
REQ-020 After rst deasserts, the first edge SHALL begin FETCH (mem_read=1, addr_sel=PC); reset during MEM or FETCH SHALL abandon the access without write_rd/write_ir.

Configuration
REQ-021 Macro CONTROL_FSM_CSR_EN defined: SYSTEM f3!=000 per REQ-014; write_csr and rd_sel=CSR reachable.
REQ-022 Macro CONTROL_FSM_CSR_EN undefined: SYSTEM opcode in DECODE -> TRAP; write_csr tied 0; rd_sel never 10.

Verification
REQ-023 ADDI (0010011), mem_complete 2 cycles after request -> write_ir once, then EXEC write_rd=1, alu 00/01, write_pc_ne=1, retire=1; 5 cycles total.
REQ-024 BEQ with branch_taken=1 -> EXEC then WB with write_pc_ex=1, alu 01/01; branch_taken=0 -> write_pc_ne in EXEC, no WB.
REQ-025 LW with mem_complete after 3 wait cycles -> mem_read held 4 cycles with addr_sel=0, then write_rd=1, rd_sel=01 in completion cycle.
REQ-026 JALR -> EXEC write_pc_ex=1 (alu 00/01), WB write_rd=1 (alu 01/10); retire only in WB.
REQ-027 opcode 0000000, then SYSTEM f3=000 -> trap=1 persists 100 cycles until rst; CSRRW without CONTROL_FSM_CSR_EN -> trap=1, write_csr never 1.
REQ-028 rst asserted mid-MEM of SW -> mem_write drops immediately, no retire; after release mem_read=1, addr_sel=1.
